// File: rtl/tcb_lite_pkg.sv
// Shared TCB-lite types: request/response records and the arbiter lock state.
// Also used by the TCB-lite protocol checker, so keep field order stable.
package tcb_lite_pkg;

    localparam int TCB_XLEN  = 32;
    localparam int TCB_BEN_W = TCB_XLEN / 8;

    typedef struct packed {
        logic                 wen;
        logic [TCB_XLEN-1:0]  adr;
        logic [TCB_BEN_W-1:0] ben;
        logic [TCB_XLEN-1:0]  wdt;
    } tcb_req_t;

    typedef struct packed {
        logic [TCB_XLEN-1:0] rdt;
        logic                err;
    } tcb_rsp_t;

    typedef enum logic {
        UNLOCKED = 1'b0,
        LOCKED   = 1'b1
    } lck_state_t;

    // Width of a manager index; a single manager still needs one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/tcb_lite_arb_dly.sv
// Delay line carrying {act, idx} of each sub transfer to the cycle its response returns.
// With DLY=0 the response arrives in the transfer cycle, so the line collapses to wires.
module tcb_lite_arb_dly #(
    parameter int DLY = 1,
    parameter int IW  = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push_act,
    input  logic [IW-1:0] push_idx,
    output logic          pop_act,
    output logic [IW-1:0] pop_idx
);

    if (DLY == 0) begin : g_bypass
        logic unused_clk_rst;
        assign unused_clk_rst = clk ^ rst;
        assign pop_act = push_act;
        assign pop_idx = push_idx;
    end else begin : g_line
        logic [DLY-1:0]         act_p;
        logic [DLY-1:0][IW-1:0] idx_p;

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                act_p <= '0;
            end else begin
                act_p[0] <= push_act;
                for (int s = 1; s < DLY; s++) begin
                    act_p[s] <= act_p[s-1];
                end
            end
        end

        // idx is only meaningful where act is set, so it carries no reset
        always_ff @(posedge clk) begin
            idx_p[0] <= push_idx;
            for (int s = 1; s < DLY; s++) begin
                idx_p[s] <= idx_p[s-1];
            end
        end

        assign pop_act = act_p[DLY-1];
        assign pop_idx = idx_p[DLY-1];
    end

endmodule

// File: rtl/tcb_lite_arbiter.sv
// Round-robin TCB-lite arbiter with bus lock for atomic sequences; routes fixed-latency
// responses back to the issuing manager.
module tcb_lite_arbiter
    import tcb_lite_pkg::*;
#(
    parameter int XLEN    = TCB_XLEN,
    parameter int MAN_NUM = 2,
    parameter int DLY     = 1
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [MAN_NUM-1:0]               man_vld,
    input  logic [MAN_NUM-1:0]               man_lck,
    input  logic [MAN_NUM-1:0]               man_wen,
    input  logic [MAN_NUM-1:0][XLEN-1:0]     man_adr,
    input  logic [MAN_NUM-1:0][XLEN/8-1:0]   man_ben,
    input  logic [MAN_NUM-1:0][XLEN-1:0]     man_wdt,
    output logic [MAN_NUM-1:0]               man_rdy,
    output logic [MAN_NUM-1:0][XLEN-1:0]     man_rdt,
    output logic [MAN_NUM-1:0]               man_err,
    output logic                             sub_vld,
    output logic                             sub_wen,
    output logic [XLEN-1:0]                  sub_adr,
    output logic [XLEN/8-1:0]                sub_ben,
    output logic [XLEN-1:0]                  sub_wdt,
    input  logic                             sub_rdy,
    input  logic [XLEN-1:0]                  sub_rdt,
    input  logic                             sub_err
);

    localparam int IW = idx_w(MAN_NUM);

    logic [IW-1:0] ptr;
    lck_state_t    lck_st;
    logic [IW-1:0] lck_own;
    logic [IW-1:0] gnt;
    logic          gnt_vld;
    logic          xfer;
    logic          rsp_act;
    logic [IW-1:0] rsp_idx;

    function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input int ofs);
        int sum;
        sum = (int'(base) + ofs) % MAN_NUM;
        return IW'(sum);
    endfunction

    // Scan offsets high to low so the nearest requester at or after ptr wins.
    // With nobody requesting, gnt rests on ptr so the sub bus shows that manager.
    always_comb begin
        gnt     = ptr;
        gnt_vld = 1'b0;
        if (lck_st == LOCKED) begin
            gnt     = lck_own;
            gnt_vld = man_vld[lck_own];
        end else begin
            for (int i = MAN_NUM - 1; i >= 0; i--) begin
                if (man_vld[wrap_add(ptr, i)]) begin
                    gnt     = wrap_add(ptr, i);
                    gnt_vld = 1'b1;
                end
            end
        end
    end

    assign sub_vld = rst & gnt_vld;
    assign sub_wen = man_wen[gnt];
    assign sub_adr = man_adr[gnt];
    assign sub_ben = man_ben[gnt];
    assign sub_wdt = man_wdt[gnt];
    assign xfer    = sub_vld & sub_rdy;

    always_comb begin
        man_rdy      = '0;
        man_rdy[gnt] = rst & sub_rdy;
    end

    // Pointer and lock only move on a completed sub transfer; a stall keeps the grant.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr     <= '0;
            lck_st  <= UNLOCKED;
            lck_own <= '0;
        end else if (xfer) begin
            ptr <= wrap_add(gnt, 1);
            if (lck_st == UNLOCKED) begin
                if (man_lck[gnt]) begin
                    lck_st  <= LOCKED;
                    lck_own <= gnt;
                end
            end else if (!man_lck[gnt]) begin
                lck_st <= UNLOCKED;
            end
        end
    end

    tcb_lite_arb_dly #(
        .DLY (DLY),
        .IW  (IW)
    ) u_dly (
        .clk      (clk),
        .rst      (rst),
        .push_act (xfer),
        .push_idx (gnt),
        .pop_act  (rsp_act),
        .pop_idx  (rsp_idx)
    );

    for (genvar m = 0; m < MAN_NUM; m++) begin : g_rsp
        logic hit;
        assign hit        = rst & rsp_act & (rsp_idx == IW'(m));
        assign man_rdt[m] = hit ? sub_rdt : '0;
        assign man_err[m] = hit & sub_err;
    end

endmodule

// File: tb/tb_tcb_lite_arbiter.sv
// Bench for tcb_lite_arbiter: one DLY=1 and one DLY=2 instance share the manager side;
// each has an echo subordinate returning the transferred address (err = adr[0]).
module tb_tcb_lite_arbiter;
    import tcb_lite_pkg::*;

    logic clk;
    logic rst;

    logic [1:0]        man_vld, man_lck, man_wen;
    logic [1:0][31:0]  man_adr, man_wdt;
    logic [1:0][3:0]   man_ben;
    logic              sub_rdy;

    logic [1:0]        rdy1, err1, rdy2, err2;
    logic [1:0][31:0]  rdt1, rdt2;
    logic              svld1, swen1, svld2, swen2;
    logic [31:0]       sadr1, swdt1, sadr2, swdt2;
    logic [3:0]        sben1, sben2;
    logic [31:0]       srdt1, srdt2;
    logic              serr1, serr2;
    logic [31:0]       e1, e2a, e2b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    tcb_lite_arbiter #(.XLEN(32), .MAN_NUM(2), .DLY(1)) u_d1 (
        .clk(clk), .rst(rst),
        .man_vld(man_vld), .man_lck(man_lck), .man_wen(man_wen), .man_adr(man_adr),
        .man_ben(man_ben), .man_wdt(man_wdt), .man_rdy(rdy1), .man_rdt(rdt1), .man_err(err1),
        .sub_vld(svld1), .sub_wen(swen1), .sub_adr(sadr1), .sub_ben(sben1), .sub_wdt(swdt1),
        .sub_rdy(sub_rdy), .sub_rdt(srdt1), .sub_err(serr1)
    );

    tcb_lite_arbiter #(.XLEN(32), .MAN_NUM(2), .DLY(2)) u_d2 (
        .clk(clk), .rst(rst),
        .man_vld(man_vld), .man_lck(man_lck), .man_wen(man_wen), .man_adr(man_adr),
        .man_ben(man_ben), .man_wdt(man_wdt), .man_rdy(rdy2), .man_rdt(rdt2), .man_err(err2),
        .sub_vld(svld2), .sub_wen(swen2), .sub_adr(sadr2), .sub_ben(sben2), .sub_wdt(swdt2),
        .sub_rdy(sub_rdy), .sub_rdt(srdt2), .sub_err(serr2)
    );

    // Echo subordinates with 1 and 2 cycles of read latency.
    always_ff @(posedge clk) begin
        e1  <= sadr1;
        e2a <= sadr2;
        e2b <= e2a;
    end
    assign srdt1 = e1;
    assign serr1 = e1[0];
    assign srdt2 = e2b;
    assign serr2 = e2b[0];

    typedef struct {
        logic [1:0]  vld;
        logic [1:0]  lck;
        logic        rdy;
        logic [31:0] a0;
        logic [31:0] a1;
        logic        e_vld;
        logic [31:0] e_adr;
        logic        adr_dc;
        logic [1:0]  e_rdy;
        logic        e_ptr;
    } vec_t;

    typedef struct {
        int          due;
        int          idx;
        logic [31:0] rdt;
        logic        err;
    } rsp_t;

    vec_t tbl[$];
    rsp_t q1[$];
    rsp_t q2[$];
    int   n_vec;
    int   n_cmp;
    int   n_err;

    function automatic vec_t mk(input logic [1:0] vld, input logic [1:0] lck, input logic rdy,
                                input logic [31:0] a0, input logic [31:0] a1,
                                input logic e_vld, input logic [31:0] e_adr, input logic adr_dc,
                                input logic [1:0] e_rdy, input logic e_ptr);
        vec_t v;
        v.vld = vld; v.lck = lck; v.rdy = rdy; v.a0 = a0; v.a1 = a1;
        v.e_vld = e_vld; v.e_adr = e_adr; v.adr_dc = adr_dc; v.e_rdy = e_rdy; v.e_ptr = e_ptr;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_rsp(input string nm, input logic [1:0][31:0] rdt, input logic [1:0] err,
                           input bit hit, input rsp_t r);
        logic [31:0] er;
        logic        ee;
        for (int m = 0; m < 2; m++) begin
            er = (hit && r.idx == m) ? r.rdt : 32'h0;
            ee = (hit && r.idx == m) ? r.err : 1'b0;
            chk($sformatf("%s_rdt%0d", nm, m), rdt[m], er);
            chk($sformatf("%s_err%0d", nm, m), {31'b0, err[m]}, {31'b0, ee});
        end
    endtask

    initial begin
        vec_t        v;
        rsp_t        r1, r2;
        bit          hit1, hit2;
        int          iss;
        logic [31:0] a;

        n_vec = 0; n_cmp = 0; n_err = 0;
        rst = 1'b0;
        man_vld = 2'b11; man_lck = '0; man_wen = '0;
        man_adr = '0; man_wdt = '0; man_ben = {4'hF, 4'hF};
        sub_rdy = 1'b1;

        // round-robin, then stall, then lock, then interleaved reads with error
        tbl.push_back(mk(2'b11, 2'b00, 1, 32'h100, 32'h200, 1, 32'h100, 0, 2'b01, 0));
        tbl.push_back(mk(2'b11, 2'b00, 1, 32'h100, 32'h200, 1, 32'h200, 0, 2'b10, 1));
        tbl.push_back(mk(2'b11, 2'b00, 1, 32'h100, 32'h200, 1, 32'h100, 0, 2'b01, 0));
        tbl.push_back(mk(2'b11, 2'b00, 1, 32'h100, 32'h200, 1, 32'h200, 0, 2'b10, 1));
        tbl.push_back(mk(2'b00, 2'b00, 1, 32'h100, 32'h200, 0, 32'h100, 0, 2'b00, 0));
        tbl.push_back(mk(2'b00, 2'b00, 1, 32'h300, 32'h400, 0, 32'h300, 0, 2'b00, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(2'b10, 2'b00, 0, 32'h300, 32'h240, 1, 32'h240, 0, 2'b00, 0));
        tbl.push_back(mk(2'b10, 2'b00, 1, 32'h300, 32'h240, 1, 32'h240, 0, 2'b10, 0));
        tbl.push_back(mk(2'b11, 2'b01, 1, 32'h500, 32'h600, 1, 32'h500, 0, 2'b01, 0));
        tbl.push_back(mk(2'b10, 2'b00, 1, 32'h504, 32'h600, 0, 32'h504, 1, 2'b00, 1));
        tbl.push_back(mk(2'b11, 2'b01, 1, 32'h504, 32'h600, 1, 32'h504, 0, 2'b01, 1));
        tbl.push_back(mk(2'b11, 2'b00, 1, 32'h508, 32'h600, 1, 32'h508, 0, 2'b01, 1));
        tbl.push_back(mk(2'b11, 2'b00, 1, 32'h508, 32'h600, 1, 32'h600, 0, 2'b10, 1));
        tbl.push_back(mk(2'b00, 2'b00, 1, 32'h700, 32'h710, 0, 32'h700, 0, 2'b00, 0));
        tbl.push_back(mk(2'b01, 2'b00, 1, 32'hAAAA_0000, 32'h0, 1, 32'hAAAA_0000, 0, 2'b01, 0));
        tbl.push_back(mk(2'b10, 2'b00, 1, 32'hAAAA_0000, 32'h5555_0001, 1, 32'h5555_0001, 0, 2'b10, 1));
        tbl.push_back(mk(2'b01, 2'b00, 1, 32'hAAAA_0000, 32'h5555_0001, 1, 32'hAAAA_0000, 0, 2'b01, 0));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(2'b00, 2'b00, 1, 32'hAAAA_0000, 32'h5555_0001, 0, 32'h5555_0001, 0, 2'b00, 1));

        // reset state with both managers requesting
        repeat (2) @(negedge clk);
        #1;
        chk("rst_sub_vld1", {31'b0, svld1}, 32'h0);
        chk("rst_man_rdy1", {30'b0, rdy1}, 32'h0);
        chk("rst_ptr", {31'b0, u_d1.ptr}, 32'h0);
        chk("rst_rdt1", rdt1[0] | rdt1[1], 32'h0);
        @(negedge clk);
        rst = 1'b1;

        for (int c = 0; c < tbl.size(); c++) begin
            if (c > 0) @(negedge clk);
            v = tbl[c];
            man_vld = v.vld; man_lck = v.lck; sub_rdy = v.rdy;
            man_adr[0] = v.a0; man_adr[1] = v.a1;
            #1;
            n_vec++;
            chk($sformatf("v%0d_sub_vld1", c), {31'b0, svld1}, {31'b0, v.e_vld});
            chk($sformatf("v%0d_sub_vld2", c), {31'b0, svld2}, {31'b0, v.e_vld});
            if (!v.adr_dc) begin
                chk($sformatf("v%0d_sub_adr1", c), sadr1, v.e_adr);
                chk($sformatf("v%0d_sub_adr2", c), sadr2, v.e_adr);
            end
            chk($sformatf("v%0d_man_rdy1", c), {30'b0, rdy1 & v.vld}, {30'b0, v.e_rdy});
            chk($sformatf("v%0d_man_rdy2", c), {30'b0, rdy2 & v.vld}, {30'b0, v.e_rdy});
            chk($sformatf("v%0d_ptr", c), {31'b0, u_d1.ptr}, {31'b0, v.e_ptr});

            hit1 = 1'b0; r1 = '{0, 0, 32'h0, 1'b0};
            if (q1.size() > 0 && q1[0].due == c) begin hit1 = 1'b1; r1 = q1.pop_front(); end
            hit2 = 1'b0; r2 = '{0, 0, 32'h0, 1'b0};
            if (q2.size() > 0 && q2[0].due == c) begin hit2 = 1'b1; r2 = q2.pop_front(); end
            chk_rsp($sformatf("v%0d_d1", c), rdt1, err1, hit1, r1);
            chk_rsp($sformatf("v%0d_d2", c), rdt2, err2, hit2, r2);

            if (v.e_vld && v.rdy) begin
                iss = v.e_rdy[1] ? 1 : 0;
                a   = (iss == 1) ? v.a1 : v.a0;
                q1.push_back('{c + 1, iss, a, a[0]});
                q2.push_back('{c + 2, iss, a, a[0]});
            end
        end
        chk("drain_q1", q1.size(), 32'h0);
        chk("drain_q2", q2.size(), 32'h0);

        // locked read with error, then reset one cycle after the transfer
        @(negedge clk);
        man_vld = 2'b01; man_lck = 2'b01; man_adr[0] = 32'hAAAA_0003; sub_rdy = 1'b1;
        #1;
        n_vec++;
        chk("t5_rdy1", {30'b0, rdy1}, 32'h1);
        chk("t5_rdy2", {30'b0, rdy2}, 32'h1);
        @(posedge clk);
        #1;
        chk("t5_d1_rdt0", rdt1[0], 32'hAAAA_0003);
        chk("t5_d1_err", {30'b0, err1}, 32'h1);
        chk("t5_d2_early", rdt2[0] | rdt2[1], 32'h0);
        chk("t5_locked", {31'b0, u_d2.lck_st}, {31'b0, LOCKED});
        @(negedge clk);
        rst = 1'b0; man_vld = 2'b11; man_lck = 2'b00;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_vec++;
            chk("t5_rst_sub_vld2", {31'b0, svld2}, 32'h0);
            chk("t5_rst_rdy2", {30'b0, rdy2}, 32'h0);
            chk("t5_rst_rdt2", rdt2[0] | rdt2[1], 32'h0);
            chk("t5_rst_err2", {30'b0, err2}, 32'h0);
            chk("t5_rst_ptr2", {31'b0, u_d2.ptr}, 32'h0);
            chk("t5_rst_lck2", {31'b0, u_d2.lck_st}, {31'b0, UNLOCKED});
            @(negedge clk);
        end
        rst = 1'b1; man_vld = 2'b00;
        for (int k = 0; k < 3; k++) begin
            #1;
            n_vec++;
            chk("t5_post_rdt1", rdt1[0] | rdt1[1], 32'h0);
            chk("t5_post_rdt2", rdt2[0] | rdt2[1], 32'h0);
            chk("t5_post_err", {30'b0, err1 | err2}, 32'h0);
            @(negedge clk);
        end
        man_vld = 2'b11; man_adr[0] = 32'h800; man_adr[1] = 32'h900;
        #1;
        n_vec++;
        chk("t5_first_rdy1", {30'b0, rdy1}, 32'h1);
        chk("t5_first_rdy2", {30'b0, rdy2}, 32'h1);
        chk("t5_first_adr1", sadr1, 32'h800);
        chk("t5_first_adr2", sadr2, 32'h800);
        @(negedge clk);
        man_vld = 2'b00;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
